mod16_pwm_tracker: RTL and testbench

Downstream consumer of the 4-bit mod-16 counter output. Samples the counter value every cycle, checks that it advances legally, and aligns to the counter's 15→0 wrap. Once aligned, it generates a 16-slot PWM waveform with a double-buffered duty setting, a per-period tick, and a count of periods. It also raises a sticky flag on any illegal counter step and re-synchronises after one.

---
 rtl/mod16_pwm_tracker.sv | 85 ++++++++
 tb/tb_mod16_pwm_tracker.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/mod16_pwm_tracker.sv
// Tracks a free-running mod-16 counter, locks onto its 15->0 wrap and
// generates a 16-slot PWM with double-buffered duty, period tick and period count.
module mod16_pwm_tracker #(
    parameter int PERIOD_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [3:0]          q_in,
    input  logic [3:0]          duty_in,
    input  logic                duty_load,
    input  logic                err_clr,
    output logic                pwm_out,
    output logic                period_tick,
    output logic [PERIOD_W-1:0] period_cnt,
    output logic                locked,
    output logic                seq_err
);

    typedef enum logic [1:0] {IDLE, SYNC, RUN} state_t;

    localparam logic [PERIOD_W-1:0] CNT_ONE = {{(PERIOD_W-1){1'b0}}, 1'b1};

    state_t     state;
    state_t     state_nxt;
    logic [3:0] q_prev;
    logic [3:0] duty_shadow;
    logic [3:0] duty_active;
    logic [3:0] duty_eff;
    logic       wrap;
    logic       bad;

    // A counter may hold its value or advance by one, modulo 16.
    function automatic logic legal_step(input logic [3:0] prev, input logic [3:0] cur);
        return (cur == prev) || (cur == prev + 4'd1);
    endfunction

    always_comb begin
        wrap      = (state != IDLE) && (q_prev == 4'hF) && (q_in == 4'h0);
        bad       = (state != IDLE) && !legal_step(q_prev, q_in);
        // On a wrap the new period already uses the shadow value.
        duty_eff  = wrap ? duty_shadow : duty_active;
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = SYNC;
            SYNC:    if (wrap) state_nxt = RUN;
            RUN:     if (bad)  state_nxt = SYNC;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            q_prev      <= 4'h0;
            duty_shadow <= 4'h0;
            duty_active <= 4'h0;
            pwm_out     <= 1'b0;
            period_tick <= 1'b0;
            period_cnt  <= '0;
            locked      <= 1'b0;
            seq_err     <= 1'b0;
        end else begin
            state       <= state_nxt;
            q_prev      <= q_in;
            locked      <= (state_nxt == RUN);
            period_tick <= wrap;
            pwm_out     <= (state_nxt == RUN) && (q_in < duty_eff);

            if (duty_load)
                duty_shadow <= duty_in;
            if (wrap)
                duty_active <= duty_shadow;

            if (wrap && (state_nxt == RUN))
                period_cnt <= period_cnt + CNT_ONE;

            // A new illegal step takes priority over a clear request.
            if (bad)
                seq_err <= 1'b1;
            else if (err_clr)
                seq_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mod16_pwm_tracker.sv
// Directed vector bench for mod16_pwm_tracker: alignment, duty buffering,
// illegal steps, hold steps, period counter rollover and asynchronous reset.
module tb_mod16_pwm_tracker;

    logic       clk;
    logic       rst;
    logic [3:0] q_in;
    logic [3:0] duty_in;
    logic       duty_load;
    logic       err_clr;

    logic       pwm_out, period_tick, locked, seq_err;
    logic [7:0] period_cnt;
    logic       pwm_out2, period_tick2, locked2, seq_err2;
    logic [1:0] period_cnt2;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] q;
        logic       dl;
        logic [3:0] di;
        logic       ec;
        logic       pwm;
        logic       tick;
        logic [7:0] cnt;
        logic       lock;
        logic       err;
    } vec_t;

    vec_t vecs[$];

    mod16_pwm_tracker #(.PERIOD_W(8)) dut (
        .clk(clk), .rst(rst), .q_in(q_in), .duty_in(duty_in),
        .duty_load(duty_load), .err_clr(err_clr),
        .pwm_out(pwm_out), .period_tick(period_tick), .period_cnt(period_cnt),
        .locked(locked), .seq_err(seq_err)
    );

    mod16_pwm_tracker #(.PERIOD_W(2)) dut2 (
        .clk(clk), .rst(rst), .q_in(q_in), .duty_in(duty_in),
        .duty_load(duty_load), .err_clr(err_clr),
        .pwm_out(pwm_out2), .period_tick(period_tick2), .period_cnt(period_cnt2),
        .locked(locked2), .seq_err(seq_err2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    function automatic void add(input int q, input int dl, input int di, input int ec,
                                input int pwm, input int tick, input int cnt,
                                input int lock, input int err);
        vec_t v;
        v.q    = 4'(q);
        v.dl   = 1'(dl);
        v.di   = 4'(di);
        v.ec   = 1'(ec);
        v.pwm  = 1'(pwm);
        v.tick = 1'(tick);
        v.cnt  = 8'(cnt);
        v.lock = 1'(lock);
        v.err  = 1'(err);
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s [%0d]: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    function automatic logic [31:0] pack8(input logic p, input logic t, input logic [7:0] c,
                                          input logic l, input logic e);
        return {20'd0, p, t, c, l, e};
    endfunction

    function automatic logic [31:0] pack2(input logic p, input logic t, input logic [1:0] c,
                                          input logic l, input logic e);
        return {26'd0, p, t, c, l, e};
    endfunction

    initial begin
        // Vector table: inputs applied before an edge, outputs expected after it.
        add(5, 0, 0, 0, 0, 0, 0, 0, 0);                    // IDLE -> SYNC, no checking
        for (int q = 6; q <= 15; q++)
            add(q, (q == 6) ? 1 : 0, 4, 0, 0, 0, 0, 0, 0); // SYNC, load duty 4
        for (int p = 1; p <= 4; p++)
            for (int q = 0; q <= 15; q++)
                add(q, 0, 0, 0, (q < 4) ? 1 : 0, (q == 0) ? 1 : 0, p, 1, 0);
        for (int q = 0; q <= 15; q++)                      // load 10 on the wrap cycle
            add(q, (q == 0) ? 1 : 0, 10, 0, (q < 4) ? 1 : 0, (q == 0) ? 1 : 0, 5, 1, 0);
        for (int q = 0; q <= 15; q++) begin                // duty 10, hold q=6 for 3 cycles
            add(q, 0, 0, 0, (q < 10) ? 1 : 0, (q == 0) ? 1 : 0, 6, 1, 0);
            if (q == 6) begin
                add(6, 0, 0, 0, 1, 0, 6, 1, 0);
                add(6, 0, 0, 0, 1, 0, 6, 1, 0);
            end
        end
        for (int q = 0; q <= 7; q++)
            add(q, 0, 0, 0, 1, (q == 0) ? 1 : 0, 7, 1, 0);
        add(9, 0, 0, 0, 0, 0, 7, 0, 1);                    // illegal 7 -> 9
        for (int q = 10; q <= 15; q++)                     // clear at q=12
            add(q, 0, 0, (q == 12) ? 1 : 0, 0, 0, 7, 0, (q < 12) ? 1 : 0);
        add(0, 0, 0, 0, 1, 1, 8, 1, 0);                    // re-lock
        for (int q = 1; q <= 4; q++)
            add(q, 0, 0, 0, 1, 0, 8, 1, 0);
        add(3, 0, 0, 1, 0, 0, 8, 0, 1);                    // bad step with err_clr: set wins
        add(4, 0, 0, 1, 0, 0, 8, 0, 0);
        for (int q = 5; q <= 15; q++)
            add(q, 0, 0, 0, 0, 0, 8, 0, 0);
        for (int q = 0; q <= 5; q++)
            add(q, 0, 0, 0, 1, (q == 0) ? 1 : 0, 9, 1, 0);

        // Reset held for two edges
        rst = 1'b0;
        q_in = 4'd0;
        duty_in = 4'd0;
        duty_load = 1'b0;
        err_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", 0, pack8(pwm_out, period_tick, period_cnt, locked, seq_err), 32'd0);
        check("reset_outputs_w2", 0, pack2(pwm_out2, period_tick2, period_cnt2, locked2, seq_err2), 32'd0);
        rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            q_in      = vecs[i].q;
            duty_load = vecs[i].dl;
            duty_in   = vecs[i].di;
            err_clr   = vecs[i].ec;
            @(posedge clk);
            #1;
            check("vector", i, pack8(pwm_out, period_tick, period_cnt, locked, seq_err),
                  pack8(vecs[i].pwm, vecs[i].tick, vecs[i].cnt, vecs[i].lock, vecs[i].err));
            check("vector_w2", i, pack2(pwm_out2, period_tick2, period_cnt2, locked2, seq_err2),
                  pack2(vecs[i].pwm, vecs[i].tick, vecs[i].cnt[1:0], vecs[i].lock, vecs[i].err));
        end
        duty_load = 1'b0;
        err_clr = 1'b0;

        // Asynchronous reset between edges while pwm_out is high
        check("pwm_high_before_reset", 0, {31'd0, pwm_out}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("async_reset", 0, pack8(pwm_out, period_tick, period_cnt, locked, seq_err), 32'd0);
        check("async_reset_w2", 0, pack2(pwm_out2, period_tick2, period_cnt2, locked2, seq_err2), 32'd0);
        @(posedge clk);
        #6;
        rst = 1'b1;

        // IDLE: 0 -> 3 is not checked
        q_in = 4'd3;
        @(posedge clk);
        #1;
        check("idle_no_check", 0, pack8(pwm_out, period_tick, period_cnt, locked, seq_err), 32'd0);
        // SYNC: 3 -> 5 is flagged, still unlocked
        q_in = 4'd5;
        @(posedge clk);
        #1;
        check("sync_bad_step", 0, pack8(pwm_out, period_tick, period_cnt, locked, seq_err),
              pack8(1'b0, 1'b0, 8'd0, 1'b0, 1'b1));
        q_in = 4'd6;
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        check("sync_err_clear", 0, {31'd0, seq_err}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
